// File: rtl/fib_datapath.sv
// Fibonacci-style datapath: 4-entry register file, down-counter and add/sub/move unit driven by an external controller.
// One opcode per cycle; every output is registered and no backpressure exists (the controller paces the opcodes).
module fib_datapath #(
    parameter int WIDTH = 8,
    parameter int size  = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [size-1:0]  opcode,
    input  logic [1:0]       R1,
    input  logic [1:0]       R2,
    input  logic [WIDTH-1:0] N,
    output logic             zero_flag,
    output logic [WIDTH-1:0] Result,
    output logic             Result_valid,
    output logic             Overflow
);

    localparam logic [size-1:0] OP_CLR  = size'(3'b000);
    localparam logic [size-1:0] OP_DEC  = size'(3'b001);
    localparam logic [size-1:0] OP_SUB  = size'(3'b010);
    localparam logic [size-1:0] OP_DECT = size'(3'b011);
    localparam logic [size-1:0] OP_INIT = size'(3'b100);
    localparam logic [size-1:0] OP_OUT  = size'(3'b101);
    localparam logic [size-1:0] OP_ADD  = size'(3'b110);
    localparam logic [size-1:0] OP_MOV  = size'(3'b111);

    logic [WIDTH-1:0] r_rf [4];
    logic [WIDTH-1:0] r_cnt;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rf_nxt [4];
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_vld_nxt;
    logic             w_ovf_nxt;

    // Operands always come from the pre-edge register file.
    assign w_a    = r_rf[R1];
    assign w_b    = r_rf[R2];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = w_a - w_b;

    always_comb begin
        w_rf_nxt  = r_rf;
        w_cnt_nxt = r_cnt;
        w_res_nxt = Result;
        w_vld_nxt = 1'b0;
        w_ovf_nxt = Overflow;
        case (opcode)
            OP_CLR: begin
                for (int i = 0; i < 4; i++) begin
                    w_rf_nxt[i] = '0;
                end
                w_cnt_nxt = N;
                w_ovf_nxt = 1'b0;
            end
            OP_INIT: begin
                w_rf_nxt[R1] = WIDTH'(1);
                w_rf_nxt[R2] = WIDTH'(1);
            end
            OP_DEC, OP_DECT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - WIDTH'(1);
                end
            end
            OP_MOV: w_rf_nxt[R1] = w_b;
            OP_ADD: begin
                w_rf_nxt[R1] = w_sum[WIDTH-1:0];
                if (w_sum[WIDTH]) begin
                    w_ovf_nxt = 1'b1;
                end
            end
            OP_SUB: w_rf_nxt[R1] = w_diff;
            OP_OUT: begin
                w_res_nxt = w_a;
                w_vld_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_cnt        <= '0;
            zero_flag    <= 1'b1;
            Result       <= '0;
            Result_valid <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            r_rf         <= w_rf_nxt;
            r_cnt        <= w_cnt_nxt;
            // Flag tracks the post-update count so it is valid alongside the new CNT.
            zero_flag    <= (w_cnt_nxt == '0);
            Result       <= w_res_nxt;
            Result_valid <= w_vld_nxt;
            Overflow     <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fib_datapath.sv
// Directed bench for fib_datapath: vector table plus hand-written multi-cycle sequences.
module tb_fib_datapath;

    logic       Clk;
    logic       Rst;
    logic [2:0] opcode;
    logic [1:0] R1;
    logic [1:0] R2;
    logic [7:0] N;
    logic       zero_flag;
    logic [7:0] Result;
    logic       Result_valid;
    logic       Overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] CLR  = 3'b000;
    localparam logic [2:0] DEC  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] DECT = 3'b011;
    localparam logic [2:0] INIT = 3'b100;
    localparam logic [2:0] OUTP = 3'b101;
    localparam logic [2:0] ADD  = 3'b110;
    localparam logic [2:0] MOV  = 3'b111;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [7:0] n;
        logic       ez;
        logic [7:0] eres;
        logic       ev;
        logic       eov;
    } vec_t;

    vec_t vec [15];

    fib_datapath #(.WIDTH(8), .size(3)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .opcode       (opcode),
        .R1           (R1),
        .R2           (R2),
        .N            (N),
        .zero_flag    (zero_flag),
        .Result       (Result),
        .Result_valid (Result_valid),
        .Overflow     (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one opcode for one cycle and sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic [2:0] op, input logic [1:0] r1,
                        input logic [1:0] r2, input logic [7:0] n);
        Rst    = rst;
        opcode = op;
        R1     = r1;
        R2     = r2;
        N      = n;
        @(posedge Clk);
        #1;
    endtask

    task automatic fib_prefix();
        step(0, CLR, 0, 0, 8'd5);
        step(0, INIT, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, MOV, 2, 0, 0);
            step(0, ADD, 0, 1, 0);
            step(0, MOV, 1, 2, 0);
        end
    endtask

    initial begin
        Rst = 1'b1; opcode = CLR; R1 = 0; R2 = 0; N = 0;

        //          rst op    r1 r2 n     ez eres ev eov
        vec[0]  = '{1, CLR,  0, 0, 8'd0, 1, 0, 0, 0};
        vec[1]  = '{0, CLR,  0, 0, 8'd5, 0, 0, 0, 0};
        vec[2]  = '{0, OUTP, 0, 0, 8'd0, 0, 0, 1, 0};
        vec[3]  = '{0, CLR,  0, 0, 8'd3, 0, 0, 0, 0};
        vec[4]  = '{0, DEC,  0, 0, 8'd0, 0, 0, 0, 0};
        vec[5]  = '{0, DECT, 0, 0, 8'd0, 0, 0, 0, 0};
        vec[6]  = '{0, DEC,  0, 0, 8'd0, 1, 0, 0, 0};
        vec[7]  = '{0, DEC,  0, 0, 8'd0, 1, 0, 0, 0};
        vec[8]  = '{0, OUTP, 3, 0, 8'd0, 1, 0, 1, 0};
        vec[9]  = '{0, INIT, 2, 2, 8'd0, 1, 0, 0, 0};
        vec[10] = '{0, OUTP, 2, 0, 8'd0, 1, 1, 1, 0};
        vec[11] = '{0, ADD,  2, 2, 8'd0, 1, 1, 0, 0};
        vec[12] = '{0, OUTP, 2, 0, 8'd0, 1, 2, 1, 0};
        vec[13] = '{0, SUB,  2, 2, 8'd0, 1, 2, 0, 0};
        vec[14] = '{0, CLR,  0, 0, 8'd0, 1, 2, 0, 0};

        @(negedge Clk);
        for (int i = 0; i < 15; i++) begin
            step(vec[i].rst, vec[i].op, vec[i].r1, vec[i].r2, vec[i].n);
            check($sformatf("vec%0d zero_flag", i), zero_flag, vec[i].ez);
            check($sformatf("vec%0d Result", i), Result, vec[i].eres);
            check($sformatf("vec%0d Result_valid", i), Result_valid, vec[i].ev);
            check($sformatf("vec%0d Overflow", i), Overflow, vec[i].eov);
        end

        // Fibonacci loop: five iterations from (1,1) leave RF0 = 13.
        fib_prefix();
        step(0, OUTP, 0, 0, 0);
        check("fib Result", Result, 13);
        check("fib valid", Result_valid, 1);
        check("fib zero_flag", zero_flag, 0);
        step(0, DEC, 0, 0, 0);
        check("fib valid drop", Result_valid, 0);
        check("fib Result hold", Result, 13);
        check("fib cnt4 zero_flag", zero_flag, 0);

        // Reset between last ADD and OUT overrides the OUT.
        fib_prefix();
        step(1, OUTP, 0, 0, 0);
        check("rst Result", Result, 0);
        check("rst valid", Result_valid, 0);
        check("rst zero_flag", zero_flag, 1);
        check("rst Overflow", Overflow, 0);
        step(0, OUTP, 0, 0, 0);
        check("rst RF0 cleared", Result, 0);
        check("rst post valid", Result_valid, 1);

        // Overflow: build 100 and 200, then 200 + 100 = 300 mod 256 = 44.
        step(0, CLR, 0, 0, 8'd1);
        step(0, INIT, 3, 3, 0);
        for (int k = 0; k < 100; k++) step(0, ADD, 1, 3, 0);
        step(0, OUTP, 1, 0, 0);
        check("ovf RF1", Result, 100);
        step(0, MOV, 0, 1, 0);
        step(0, ADD, 0, 1, 0);
        check("ovf none at 200", Overflow, 0);
        step(0, OUTP, 0, 0, 0);
        check("ovf RF0 200", Result, 200);
        step(0, ADD, 0, 1, 0);
        check("ovf set", Overflow, 1);
        step(0, SUB, 0, 0, 0);
        check("ovf sticky after SUB", Overflow, 1);
        step(0, ADD, 0, 1, 0);
        step(0, OUTP, 0, 0, 0);
        check("ovf RF0 100", Result, 100);
        check("ovf sticky", Overflow, 1);
        step(0, CLR, 0, 0, 8'd2);
        check("ovf cleared", Overflow, 0);

        // Recompute the wrap value directly: RF0=200 then ADD -> 44.
        step(0, INIT, 3, 3, 0);
        for (int k = 0; k < 100; k++) step(0, ADD, 1, 3, 0);
        step(0, MOV, 0, 1, 0);
        step(0, ADD, 0, 1, 0);
        step(0, ADD, 0, 1, 0);
        step(0, OUTP, 0, 0, 0);
        check("wrap RF0 44", Result, 44);
        check("wrap Overflow", Overflow, 1);

        // Back-to-back OUTs on RF0 then RF1, then SUB with R1 == R2.
        step(0, CLR, 0, 0, 8'd2);
        step(0, INIT, 0, 1, 0);
        step(0, ADD, 0, 1, 0);
        step(0, OUTP, 0, 0, 0);
        check("b2b first Result", Result, 2);
        check("b2b first valid", Result_valid, 1);
        step(0, OUTP, 1, 0, 0);
        check("b2b second Result", Result, 1);
        check("b2b second valid", Result_valid, 1);
        step(0, DEC, 0, 0, 0);
        check("b2b valid drop", Result_valid, 0);
        check("b2b Result hold", Result, 1);
        step(0, SUB, 0, 0, 0);
        step(0, OUTP, 0, 0, 0);
        check("sub self", Result, 0);
        step(0, MOV, 1, 1, 0);
        step(0, OUTP, 1, 0, 0);
        check("mov self", Result, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
